// File: rtl/usr_rst_req.sv
// User-reset requester: debounced button or software request -> fixed-width usr_rst pulse,
// then waits for the generated core reset to release and enforces a hold-off.
`timescale 1ns/1ps
module usr_rst_req #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int HOLDOFF_CYCLES  = 256,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             sys_rstn,
    input  logic             btn_in,
    input  logic             sw_req,
    input  logic             core_rstn,
    output logic             usr_rst,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] rst_count
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int MAX_A = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_T = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
    localparam int TMR_W = $clog2(MAX_T) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic             btn_s1_q, btn_s2_q;
    logic             crst_s1_q, crst_s_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_lvl_q, deb_lvl_d;
    logic             deb_prev_q;
    logic             press, req;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             usr_rst_q, usr_rst_d;
    logic             crst_hi_q, crst_hi_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] rst_count_q, rst_count_d;

    // Both the button and the fed-back core reset are asynchronous to clk.
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            crst_s1_q  <= 1'b0;
            crst_s_q   <= 1'b0;
            deb_cnt_q  <= '0;
            deb_lvl_q  <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            btn_s1_q   <= btn_in;
            btn_s2_q   <= btn_s1_q;
            crst_s1_q  <= core_rstn;
            crst_s_q   <= crst_s1_q;
            deb_cnt_q  <= deb_cnt_d;
            deb_lvl_q  <= deb_lvl_d;
            deb_prev_q <= deb_lvl_q;
        end
    end

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_lvl_d = deb_lvl_q;
        if (btn_s2_q == deb_lvl_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_lvl_d = ~deb_lvl_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    assign press = deb_lvl_q & ~deb_prev_q;
    assign req   = press | sw_req;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        usr_rst_d   = usr_rst_q;
        crst_hi_d   = crst_hi_q;
        timeout_d   = timeout_q;
        rst_count_d = rst_count_q;
        case (state_q)
            ST_IDLE: begin
                usr_rst_d = 1'b0;
                if (req) begin
                    state_d   = ST_PULSE;
                    tmr_d     = '0;
                    usr_rst_d = 1'b1;
                    if (rst_count_q != {CNT_W{1'b1}})
                        rst_count_d = rst_count_q + 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d   = ST_WAIT;
                    tmr_d     = '0;
                    usr_rst_d = 1'b0;
                    crst_hi_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // Release is only trusted after two consecutive synced-high samples.
                crst_hi_d = crst_s_q;
                if (crst_s_q && crst_hi_q) begin
                    state_d = ST_HOLD;
                    tmr_d   = '0;
                end else if (tmr_q == TO_LAST) begin
                    state_d   = ST_HOLD;
                    tmr_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tmr_d     = '0;
                usr_rst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            usr_rst_q   <= 1'b0;
            crst_hi_q   <= 1'b0;
            timeout_q   <= 1'b0;
            rst_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            usr_rst_q   <= usr_rst_d;
            crst_hi_q   <= crst_hi_d;
            timeout_q   <= timeout_d;
            rst_count_q <= rst_count_d;
        end
    end

    assign usr_rst   = usr_rst_q;
    assign busy      = (state_q != ST_IDLE);
    assign timeout   = timeout_q;
    assign rst_count = rst_count_q;

endmodule
